// File: rtl/regbank_mp.sv
// Multi-port register bank: NUM_RD combinational read ports, a general and a link
// write port, optional same-cycle write bypass and a per-register pending scoreboard.
module regbank_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 3,
  parameter int LINK_REG = NUM_REGS - 1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_link_en,
  input  logic [DATA_W-1:0]        i_link_data,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_pend_set,
  input  logic [ADDR_W-1:0]        i_pend_addr,
  output logic                     o_pend_any
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_set;

  // Index 0 is never written, set or cleared, so it stays at its reset value.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_clr[i] = (i_wr_en && (i_wr_addr == ADDR_W'(i))) || (i_link_en && (i == LINK_REG));
      w_set[i] = i_pend_set && (i_pend_addr == ADDR_W'(i));
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_pending <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_link_en && (i == LINK_REG)) r_regs[i] <= i_link_data;
        else if (i_wr_en && (i_wr_addr == ADDR_W'(i))) r_regs[i] <= i_wr_data;
      end
      // A newly issued destination owns the register even if it is written this edge.
      r_pending <= w_set | (r_pending & ~w_clr);
    end
  end

  assign o_pend_any = |r_pending;

  always_comb begin
    logic [ADDR_W-1:0] v_a;
    logic [DATA_W-1:0] v_d;
    logic              v_b;
    o_rd_data = '0;
    o_rd_busy = '0;
    v_a = '0;
    v_d = '0;
    v_b = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      v_a = i_rd_addr[k*ADDR_W +: ADDR_W];
      v_d = r_regs[v_a];
      v_b = r_pending[v_a];
      if (BYPASS) begin
        if (i_link_en && (v_a == ADDR_W'(LINK_REG))) v_d = i_link_data;
        else if (i_wr_en && (v_a == i_wr_addr))     v_d = i_wr_data;
        if (w_clr[v_a]) v_b = 1'b0;
      end
      if ((v_a == '0) || !i_reset) begin
        v_d = '0;
        v_b = 1'b0;
      end
      o_rd_data[k*DATA_W +: DATA_W] = v_d;
      o_rd_busy[k]                  = v_b;
    end
  end

endmodule

// File: doc/regbank_mp.md
# regbank_mp

Parametrised multi-port register bank for the MIPS datapath, succeeding the single-write, fixed-size bank. It provides a configurable number of combinational read ports, one general write port and a dedicated link write port for `jal`. It has an optional write-to-read bypass and a per-register pending scoreboard that lets the decode stage detect read-after-write hazards without a separate hazard unit. It sits between decode (read/issue) and write-back (write/clear).

## Interface
- `DATA_W`, 32: register width in bits.
- `NUM_REGS`, 32: number of architectural registers, ≥ 2, power of two.
- `ADDR_W`, $clog2(NUM_REGS): register index width.
- `NUM_RD`, 3: number of read ports (rs, rt, rd in the current datapath).
- `LINK_REG`, NUM_REGS-1: index written by the link port.
- `BYPASS`, 1: 1 means a same-cycle write is forwarded to matching read ports; 0 means reads see the old value.

Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `wr_en` in 1: general write enable.
- `wr_addr` in ADDR_W: general write index.
- `wr_data` in DATA_W: general write data.
- `link_en` in 1: link write enable (`jal`).
- `link_data` in DATA_W: return address (PC+8 from the fetch path).
- `rd_addr` in NUM_RD*ADDR_W: packed read indices; port k at bits [k*ADDR_W +: ADDR_W].
- `rd_data` out NUM_RD*DATA_W: packed read data, same packing.
- `rd_busy` out NUM_RD: port k's register has a pending write.
- `pend_set` in 1: issue of an instruction with a destination; marks `pend_addr` pending.
- `pend_addr` in ADDR_W: destination index being issued.
- `pend_any` out 1: OR of all pending bits (drain indicator).

## Operation
- Register 0 is hardwired to zero. Writes to index 0 on either port are discarded. Reads of index 0 return 0. Pending for index 0 never sets, and `rd_busy` for index 0 is always 0.
- General write: on a rising edge with `wr_en`=1 and `wr_addr`≠0, `regs[wr_addr]` ← `wr_data`.
- Link write: on a rising edge with `link_en`=1, `regs[LINK_REG]` ← `link_data`.
- Both enabled, with `wr_addr`=`LINK_REG`: the link write wins and `wr_data` is dropped. Both enabled with different indices: both writes commit.
- Reads are combinational: `rd_data[k]` = `regs[rd_addr[k]]`.
- With `BYPASS`=1, the newest write is forwarded. If `link_en` and `rd_addr[k]`=`LINK_REG`, the port returns `link_data`. Otherwise, if `wr_en` and `rd_addr[k]`=`wr_addr`≠0, it returns `wr_data`. Index 0 still returns 0.
- Scoreboard: `pending[NUM_REGS]` bits.
  - Set on a rising edge when `pend_set`=1 and `pend_addr`≠0.
  - Cleared on a rising edge by a write to that index: `wr_en` with `wr_addr`, or `link_en` for `LINK_REG`.
  - Set and clear on the same index in the same cycle: set wins, because the newer instruction owns the register.
  - A clear of a non-pending index has no effect.
- `rd_busy[k]` = `pending[rd_addr[k]]`. With `BYPASS`=1 it is masked to 0 when a clearing write to that index occurs in the same cycle.
- Reset (`reset`=0), asynchronously: all registers ← 0, all pending bits ← 0, hence `rd_data` = 0, `rd_busy` = 0, `pend_any` = 0. Inputs are ignored while `reset` is low. The first update happens on the first rising edge after `reset` goes high. Reset asserted mid-write aborts that write.

## Timing
- Write latency is 1 edge. A value is visible on non-bypassed reads in the cycle after the edge, and in the same cycle when `BYPASS`=1.
- Read latency is 0, combinational from `rd_addr`, register state and (when `BYPASS`=1) the write ports.
- Scoreboard: a set at edge t makes `rd_busy` high from t onward. A clear at edge t makes it low from t onward, or in the cycle before t when `BYPASS`=1.
- No multicycle paths. Reset deassertion is synchronised externally.

## Test plan
- Reset: preload r5=0xDEADBEEF, drop `reset` between edges → `rd_data` reads 0 immediately, `pend_any`=0.
- r0: `wr_en`=1, `wr_addr`=0, `wr_data`=0xFFFFFFFF, then read r0 → 0. `pend_set` on index 0 → `rd_busy`=0.
- Link collision: `wr_en`=1, `wr_addr`=31, `wr_data`=0x11, and `link_en`=1, `link_data`=0x400008 in the same cycle → r31 reads 0x400008. Repeat with `wr_addr`=4 → r4=0x11 and r31=0x400008.
- Bypass, `BYPASS`=1: same-cycle write r7=0x1234 with `rd_addr[0]`=7 → `rd_data[0]`=0x1234 before the edge. With `BYPASS`=0 → old value until after the edge.
- Scoreboard: `pend_set` r9, then read r9 → `rd_busy`=1, `pend_any`=1. Write r9=0x55 → `rd_busy`=0 and data 0x55. Set and write r9 in the same cycle → remains busy.
- Parameter sweep: `NUM_REGS`=16, `DATA_W`=64, `NUM_RD`=4 → write and read every index on every port, `LINK_REG`=15 receives `link_data`.
